split_verdict_collector: RTL and testbench
==========================================

Name: split_verdict_collector

Overview:
- Downstream consumer of the split_N constraint-check stages.
- Each candidate sample (ID plus packed variable image) is driven into all NUM_SPLITS split blocks in parallel. Those blocks return one combinational verdict bit each.
- This block ANDs the verdicts, buffers accepted sample IDs in a FIFO for the sampler back-end, counts rejections, and declares the constraint set unsatisfiable-in-practice after MAX_RETRY consecutive rejects.

Parameters:
- NUM_SPLITS, 16, number of split verdict inputs.
- ID_W, 16, sample ID width.
- DEPTH, 8, accepted-ID FIFO depth (power of 2, ≥2).
- MAX_RETRY, 1024, consecutive rejects that trip the unsat flag (≥1).
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  candidate sample valid.
- in_ready  out  1  block can take a candidate this cycle.
- in_id  in  ID_W  candidate sample ID.
- split_x  in  NUM_SPLITS  verdicts for in_id, same cycle as in_valid.
- out_valid  out  1  accepted ID available at FIFO head.
- out_ready  in  1  consumer takes head.
- out_id  out  ID_W  FIFO head ID.
- unsat  out  1  sticky: MAX_RETRY consecutive rejects reached.
- clear_unsat  in  1  re-arm after unsat.
- accept_cnt  out  CNT_W  total accepted, saturating.
- reject_cnt  out  CNT_W  total rejected, saturating.

Behaviour:
- Reset values: in_ready=0 in the reset cycle, then it follows the rules below.
- Reset values: out_valid=0, out_id=0, unsat=0, accept_cnt=0, reject_cnt=0, FIFO empty, consecutive-reject counter=0, state=RUN.
- States: RUN and HALT.
  - RUN → HALT when a reject brings consec to MAX_RETRY.
  - HALT → RUN on clear_unsat=1. consec clears; unsat clears the next cycle.
- in_ready:
  - In RUN, in_ready = !fifo_full || (out_valid && out_ready). Same-cycle pop frees a slot.
  - In HALT, in_ready = 0.
- Handshake fires when in_valid && in_ready. verdict = &split_x (AND of all enabled bits).
  - Accept: push in_id; accept_cnt+1; consec→0.
  - Reject: no push; reject_cnt+1; consec+1.
- Input stalls: an accept-ready candidate is back-pressured while the FIFO is full. Rejects are also stalled when full, because in_ready is not verdict-dependent. No combinational path from split_x to in_ready.
- FIFO:
  - out_valid = !empty; out_id = head entry, registered storage.
  - Push becomes visible at the output 1 cycle after the fire.
  - Simultaneous push and pop when full is legal; the count is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH; there is an extra wrap bit for full/empty.
- Counters saturate at 2^CNT_W−1 and never wrap. consec is wide enough for MAX_RETRY and saturates there.
- unsat asserts the cycle after the tripping reject and holds until cleared. FIFO contents still drain during HALT.
- clear_unsat in RUN has no effect.
- Reset mid-operation discards FIFO contents and counters with no output glitch beyond the values above.

Optional Feature:
- Macro: SPLIT_VERDICT_MASK_EN.
- Defined: adds input port split_mask [NUM_SPLITS], sampled every cycle. verdict = &(split_x | ~split_mask), so masked-off splits always pass. An all-zero mask accepts everything.
- Undefined: no port; every split participates.

Decomposition:
- Package split_pkg holds:
  - sample-ID typedef (logic [ID_W-1:0]);
  - state enum {RUN, HALT};
  - default constants for NUM_SPLITS, MAX_RETRY, CNT_W.
- Sub-module split_id_fifo: synchronous FIFO with push/pop, full/empty and registered head. The collector instantiates it once.

Test Plan:
- Accept path: split_x all ones, in_id=0x0005, out_ready=1 → out_valid=1 with out_id=0x0005 one cycle later; accept_cnt=1.
- Full FIFO: DEPTH=8, out_ready=0, 9 accepted candidates → 8 accepted and in_ready=0. Then one pop plus push in the same cycle keeps the count at 8 and out_id order preserved.
- Unsat: MAX_RETRY=4, split_x=0xFFFE for 4 candidates → unsat=1 the cycle after the 4th; in_ready=0. clear_unsat pulse → unsat=0 and input resumes.
- Consec reset: 3 rejects, 1 accept, 3 rejects with MAX_RETRY=4 → unsat stays 0; reject_cnt=6.
- Saturation: CNT_W=4 with 20 accepts → accept_cnt holds 15.
- Mask (with SPLIT_VERDICT_MASK_EN): split_mask=0x7FFF, split_x=0x7FFF → accepted.

Source files
------------

// File: rtl/split_pkg.sv
// split_pkg: shared types and default sizing for the split verdict collector
package split_pkg;
  localparam int NUM_SPLITS_DEF = 16;
  localparam int ID_W_DEF = 16;
  localparam int MAX_RETRY_DEF = 1024;
  localparam int CNT_W_DEF = 32;
  typedef logic [ID_W_DEF-1:0] sample_id_t;
  typedef enum logic {RUN, HALT} state_t;
endpackage

// File: rtl/split_id_fifo.sv
// split_id_fifo: synchronous FIFO of accepted sample IDs with wrap-bit full/empty
module split_id_fifo import split_pkg::*; #(
  parameter int W = ID_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  // pointer update; a pop frees the slot a same-cycle push into a full FIFO needs
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = do_push ? wr_q + (PW+1)'(1) : wr_q;
    rd_d = do_pop ? rd_q + (PW+1)'(1) : rd_q;
    dout = empty ? '0 : mem_q[rd_q[PW-1:0]];
  end
  // pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage write; contents need no reset since empty masks the head
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= din;
  end
endmodule

// File: rtl/split_verdict_collector.sv
// split_verdict_collector: ANDs split verdicts, queues accepted IDs, tracks rejects (SPLIT_VERDICT_MASK_EN adds split_mask)
module split_verdict_collector import split_pkg::*; #(
  parameter int NUM_SPLITS = NUM_SPLITS_DEF,
  parameter int ID_W = ID_W_DEF,
  parameter int DEPTH = 8,
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ID_W-1:0]       in_id,
  input  logic [NUM_SPLITS-1:0] split_x,
`ifdef SPLIT_VERDICT_MASK_EN
  input  logic [NUM_SPLITS-1:0] split_mask,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_W-1:0]       out_id,
  output logic                  unsat,
  input  logic                  clear_unsat,
  output logic [CNT_W-1:0]      accept_cnt,
  output logic [CNT_W-1:0]      reject_cnt
);
  localparam int CW = $clog2(MAX_RETRY + 1);
  state_t state_q, state_d;
  logic [CW-1:0] consec_q, consec_d;
  logic [CNT_W-1:0] acc_q, acc_d, rej_q, rej_d;
  logic full, empty, verdict, fire, accept, reject;
  // handshake, verdict and next-state; in_ready never depends on split_x
  always_comb begin
`ifdef SPLIT_VERDICT_MASK_EN
    verdict = &(split_x | ~split_mask);
`else
    verdict = &split_x;
`endif
    out_valid = !empty;
    in_ready = !rst && state_q == RUN && (!full || (!empty && out_ready));
    fire = in_valid && in_ready;
    accept = fire && verdict;
    reject = fire && !verdict;
    acc_d = accept && acc_q != '1 ? acc_q + CNT_W'(1) : acc_q;
    rej_d = reject && rej_q != '1 ? rej_q + CNT_W'(1) : rej_q;
    consec_d = (state_q == HALT && clear_unsat) || accept ? '0
             : reject && consec_q != CW'(MAX_RETRY) ? consec_q + CW'(1) : consec_q;
    state_d = state_q == HALT ? (clear_unsat ? RUN : HALT)
            : (reject && consec_d == CW'(MAX_RETRY) ? HALT : RUN);
    unsat = state_q == HALT;
    accept_cnt = acc_q;
    reject_cnt = rej_q;
  end
  // state and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      consec_q <= '0;
      acc_q <= '0;
      rej_q <= '0;
    end else begin
      state_q <= state_d;
      consec_q <= consec_d;
      acc_q <= acc_d;
      rej_q <= rej_d;
    end
  end
  split_id_fifo #(.W(ID_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .din(in_id),
    .pop(out_ready),
    .full(full),
    .empty(empty),
    .dout(out_id)
  );
endmodule

// File: tb/tb_split_verdict_collector.sv
// tb_split_verdict_collector: directed table and sequence checks for the collector
module tb_split_verdict_collector;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0, clear_unsat = 0;
  logic in_ready, out_valid, unsat;
  logic [15:0] in_id = 0, split_x = 0, out_id;
`ifdef SPLIT_VERDICT_MASK_EN
  logic [15:0] split_mask = 16'hFFFF;
`endif
  logic [3:0] accept_cnt, reject_cnt;
  int total = 0, bad = 0;

  split_verdict_collector #(.NUM_SPLITS(16), .ID_W(16), .DEPTH(8), .MAX_RETRY(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .split_x(split_x),
`ifdef SPLIT_VERDICT_MASK_EN
    .split_mask(split_mask),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .unsat(unsat),
    .clear_unsat(clear_unsat), .accept_cnt(accept_cnt), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [15:0] id; logic [15:0] sx; logic ordy;
    logic e_rdy; logic e_ov; logic [15:0] e_oid; logic e_unsat; logic [3:0] e_acc; logic [3:0] e_rej;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0; clear_unsat = 0; in_id = 0; split_x = 0;
    tick();
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h0005, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0};
    tbl[1] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 4'd1, 4'd0};
    tbl[2] = '{1'b1, 16'h0011, 16'hFFFE, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd1, 4'd0};
    tbl[3] = '{1'b1, 16'h0012, 16'h7FFF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd1, 4'd1};
    tbl[4] = '{1'b1, 16'h0013, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd1, 4'd2};
    tbl[5] = '{1'b1, 16'h0020, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd1, 4'd3};
    tbl[6] = '{1'b1, 16'h0014, 16'hFFFE, 1'b1, 1'b1, 1'b1, 16'h0020, 1'b0, 4'd2, 4'd3};
    tbl[7] = '{1'b1, 16'h0015, 16'hFFFE, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd2, 4'd4};
    tbl[8] = '{1'b1, 16'h0016, 16'hFFFE, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd2, 4'd5};
    tbl[9] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd2, 4'd6};

    do_reset();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_id", out_id, 0);
    chk("reset_unsat", unsat, 0);
    chk("reset_accept_cnt", accept_cnt, 0);
    chk("reset_reject_cnt", reject_cnt, 0);
    chk("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].iv; in_id = tbl[i].id; split_x = tbl[i].sx; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_id", i), out_id, tbl[i].e_oid);
      chk($sformatf("tbl%0d_unsat", i), unsat, tbl[i].e_unsat);
      chk($sformatf("tbl%0d_accept_cnt", i), accept_cnt, tbl[i].e_acc);
      chk($sformatf("tbl%0d_reject_cnt", i), reject_cnt, tbl[i].e_rej);
      tick();
    end

    do_reset();
    split_x = 16'hFFFF;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_id = 16'h0100 + 16'(i);
      #1;
      chk($sformatf("full_in_ready_%0d", i), in_ready, i < 8);
      tick();
    end
    out_ready = 1;
    #1;
    chk("full_out_valid", out_valid, 1);
    chk("full_head", out_id, 16'h0100);
    chk("full_pop_frees_slot", in_ready, 1);
    chk("full_accept_cnt", accept_cnt, 8);
    tick();
    in_valid = 0; out_ready = 0;
    #1;
    chk("full_still_full", in_ready, 0);
    chk("full_head_after_swap", out_id, 16'h0101);
    chk("full_accept_cnt2", accept_cnt, 9);
    out_ready = 1;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk($sformatf("drain_valid_%0d", j), out_valid, 1);
      chk($sformatf("drain_id_%0d", j), out_id, 16'h0101 + 16'(j));
      tick();
    end
    chk("drain_empty", out_valid, 0);
    tick();
    chk("pop_empty_ignored", out_valid, 0);
    chk("pop_empty_ready", in_ready, 1);

    do_reset();
    in_valid = 1; in_id = 16'h0077; split_x = 16'hFFFF;
    #1;
    tick();
    split_x = 16'hFFFE;
    for (int k = 0; k < 4; k++) begin
      in_id = 16'h0030 + 16'(k);
      #1;
      chk($sformatf("unsat_pre_%0d", k), unsat, 0);
      chk($sformatf("unsat_rdy_%0d", k), in_ready, 1);
      tick();
    end
    chk("unsat_set", unsat, 1);
    chk("unsat_in_ready", in_ready, 0);
    chk("unsat_reject_cnt", reject_cnt, 4);
    chk("unsat_head", out_id, 16'h0077);
    tick();
    chk("halt_no_fire", reject_cnt, 4);
    in_valid = 0; out_ready = 1;
    tick();
    chk("halt_drain", out_valid, 0);
    chk("halt_sticky", unsat, 1);
    out_ready = 0; clear_unsat = 1;
    #1;
    chk("clear_cycle_unsat", unsat, 1);
    tick();
    clear_unsat = 0;
    #1;
    chk("cleared_unsat", unsat, 0);
    chk("cleared_in_ready", in_ready, 1);
    in_valid = 1; in_id = 16'h0099; split_x = 16'hFFFF;
    tick();
    in_valid = 0;
    #1;
    chk("resume_accept_cnt", accept_cnt, 2);
    chk("resume_out_id", out_id, 16'h0099);
    in_valid = 1; split_x = 16'h0000; clear_unsat = 1;
    for (int k = 0; k < 3; k++) tick();
    clear_unsat = 0;
    #1;
    chk("clear_in_run_ignored_pre", unsat, 0);
    tick();
    in_valid = 0;
    #1;
    chk("clear_in_run_ignored", unsat, 1);

    do_reset();
    in_valid = 1; out_ready = 1; split_x = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      in_id = 16'(i);
      tick();
    end
    in_valid = 0;
    #1;
    chk("sat_accept_cnt", accept_cnt, 15);
    chk("sat_reject_cnt", reject_cnt, 0);

`ifdef SPLIT_VERDICT_MASK_EN
    do_reset();
    split_mask = 16'h7FFF; split_x = 16'h7FFF; in_valid = 1; in_id = 16'h0042;
    tick();
    split_mask = 16'hFFFF;
    tick();
    in_valid = 0;
    #1;
    chk("mask_accept", accept_cnt, 1);
    chk("mask_full_reject", reject_cnt, 1);
    chk("mask_out_id", out_id, 16'h0042);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
